// File: rtl/pixel_readout_capture.sv
// pixel_readout_capture: samples a 2x2 pixel frame off the readout strobes
// and streams the four pixels out over a valid/ready port.
module pixel_readout_capture #(
    parameter int DW     = 8,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          erase,
    input  logic          expose,
    input  logic          convert,
    input  logic          read12,
    input  logic          read34,
    input  logic [DW-1:0] pixData1,
    input  logic [DW-1:0] pixData2,
    input  logic [DW-1:0] pixData3,
    input  logic [DW-1:0] pixData4,
    output logic [DW-1:0] pix_data,
    output logic [1:0]    pix_idx,
    output logic          pix_valid,
    input  logic          pix_ready,
    output logic          pix_last,
    output logic          frame_done,
    output logic [7:0]    frame_count,
    output logic          seq_err,
    output logic          overrun
);

    typedef enum logic [2:0] {
        IDLE, ARMED, CONV, RD12, WAIT34, RD34, DRAIN
    } state_t;

    localparam logic [3:0] SET4 = 4'(SETTLE);
    localparam bit         ONE  = (SETTLE == 1);

    state_t        state;
    logic [3:0]    cnt;
    logic [DW-1:0] pbuf [4];

    // expose carries no information for capture; ARMED ignores it
    logic unused_expose;
    assign unused_expose = expose;

    // cnt stays below SETTLE (<=15) in RD states, so +1 cannot wrap
    logic [3:0] cnt_nx;
    logic       settled;
    logic [1:0] idx_nx;
    assign cnt_nx  = cnt + 4'd1;
    assign settled = (cnt_nx == SET4);
    assign idx_nx  = pix_idx + 2'd1;

    // capture sequencer, frame buffer and registered stream outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            for (int i = 0; i < 4; i++) pbuf[i] <= '0;
            pix_data    <= '0;
            pix_idx     <= '0;
            pix_valid   <= 1'b0;
            pix_last    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            seq_err     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (erase) state <= ARMED;
                end
                ARMED: begin
                    if (!erase && convert) state <= CONV;
                end
                CONV: begin
                    if (erase) begin
                        state <= ARMED;
                    end else if (read34) begin
                        seq_err <= 1'b1;
                        state   <= IDLE;
                    end else if (read12) begin
                        cnt <= 4'd1;
                        if (ONE) begin
                            pbuf[0] <= pixData1;
                            pbuf[1] <= pixData2;
                            state   <= WAIT34;
                        end else begin
                            state <= RD12;
                        end
                    end
                end
                RD12: begin
                    if (erase) begin
                        state <= ARMED;
                    end else if (read34 || !read12) begin
                        seq_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt_nx;
                        if (settled) begin
                            pbuf[0] <= pixData1;
                            pbuf[1] <= pixData2;
                            state   <= WAIT34;
                        end
                    end
                end
                WAIT34: begin
                    if (erase) begin
                        state <= ARMED;
                    end else if (read34 && read12) begin
                        seq_err <= 1'b1;
                        state   <= IDLE;
                    end else if (read34) begin
                        cnt <= 4'd1;
                        if (ONE) begin
                            pbuf[2]   <= pixData3;
                            pbuf[3]   <= pixData4;
                            pix_data  <= pbuf[0];
                            pix_idx   <= 2'd0;
                            pix_last  <= 1'b0;
                            pix_valid <= 1'b1;
                            state     <= DRAIN;
                        end else begin
                            state <= RD34;
                        end
                    end
                end
                RD34: begin
                    if (erase) begin
                        state <= ARMED;
                    end else if (read12 || !read34) begin
                        seq_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt_nx;
                        if (settled) begin
                            pbuf[2]   <= pixData3;
                            pbuf[3]   <= pixData4;
                            pix_data  <= pbuf[0];
                            pix_idx   <= 2'd0;
                            pix_last  <= 1'b0;
                            pix_valid <= 1'b1;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // a new erase cannot be honoured; the frame it starts is lost
                    if (erase) overrun <= 1'b1;
                    if (pix_ready) begin
                        if (pix_idx == 2'd3) begin
                            pix_valid   <= 1'b0;
                            pix_last    <= 1'b0;
                            frame_done  <= 1'b1;
                            frame_count <= frame_count + 8'd1;
                            state       <= IDLE;
                        end else begin
                            pix_idx  <= idx_nx;
                            pix_data <= pbuf[idx_nx];
                            pix_last <= (idx_nx == 2'd3);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_readout_capture.sv
// tb_pixel_readout_capture: directed frames against pixel_readout_capture
// with hand-computed pixel streams, error flags and frame counts.
module tb_pixel_readout_capture;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          erase = 0, expose = 0, convert = 0;
    logic          read12 = 0, read34 = 0;
    logic [DW-1:0] pixData1 = 0, pixData2 = 0, pixData3 = 0, pixData4 = 0;
    logic [DW-1:0] pix_data;
    logic [1:0]    pix_idx;
    logic          pix_valid, pix_ready = 0, pix_last, frame_done;
    logic [7:0]    frame_count;
    logic          seq_err, overrun;

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_cnt = 0;

    pixel_readout_capture #(.DW(DW), .SETTLE(2)) dut (
        .clk(clk), .reset(reset),
        .erase(erase), .expose(expose), .convert(convert),
        .read12(read12), .read34(read34),
        .pixData1(pixData1), .pixData2(pixData2),
        .pixData3(pixData3), .pixData4(pixData4),
        .pix_data(pix_data), .pix_idx(pix_idx),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_last(pix_last), .frame_done(frame_done),
        .frame_count(frame_count),
        .seq_err(seq_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, pix_valid, 0);
        chk({tag, ".data"}, pix_data, 0);
        chk({tag, ".idx"}, pix_idx, 0);
        chk({tag, ".last"}, pix_last, 0);
        chk({tag, ".done"}, frame_done, 0);
        chk({tag, ".fcnt"}, frame_count, 0);
        chk({tag, ".serr"}, seq_err, 0);
        chk({tag, ".ovr"}, overrun, 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        #2;
        chk_zero(tag);
        cyc();
        reset = 1'b1;
        exp_cnt = 0;
        cyc();
    endtask

    task automatic arm();
        erase = 1; cyc(); erase = 0;
        expose = 1; cyc(); expose = 0;
        convert = 1; cyc(); convert = 0;
    endtask

    // d = {p4,p3,p2,p1}; ends just after the read34 capture edge
    task automatic reads(input logic [31:0] d);
        read12 = 1; pixData1 = d[7:0]; pixData2 = d[15:8];
        cyc(); cyc(); cyc();
        read12 = 0; pixData1 = 0; pixData2 = 0;
        read34 = 1; pixData3 = d[23:16]; pixData4 = d[31:24];
        cyc(); cyc();
        read34 = 0; pixData3 = 0; pixData4 = 0;
        chk("latency", pix_valid, 1);
    endtask

    task automatic drain(input logic [31:0] d, input logic [7:0] rpat,
                         input int ncyc);
        int         k = 0;
        int         c = 0;
        bit         held = 0;
        logic [7:0] prev = 0;
        while (k < 4 && c < 40) begin
            pix_ready = rpat[c % 8];
            if (held) chk("hold", pix_data, prev);
            chk("valid", pix_valid, 1);
            if (pix_valid && pix_ready) begin
                chk("data", pix_data, d[k*8 +: 8]);
                chk("idx", pix_idx, k);
                chk("last", pix_last, k == 3);
                k++;
            end
            held = pix_valid && !pix_ready;
            prev = pix_data;
            cyc();
            c++;
        end
        chk("xfers", k, 4);
        if (ncyc > 0) chk("cycles", c, ncyc);
        chk("fdone", frame_done, 1);
        chk("vdrop", pix_valid, 0);
        exp_cnt++;
        chk("fcount", frame_count, exp_cnt);
        pix_ready = 0;
        cyc();
        chk("fdone1", frame_done, 0);
    endtask

    task automatic no_out(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk(tag, pix_valid, 0);
            cyc();
        end
    endtask

    initial begin
        cyc(); cyc();
        chk_zero("rst");
        reset = 1'b1;
        cyc();

        // nominal frame, ready tied high
        arm();
        reads(32'h44332211);
        drain(32'h44332211, 8'hFF, 4);
        chk("nom.serr", seq_err, 0);

        // backpressure 0,0,1,0,1,1,0,1
        arm();
        reads(32'h44332211);
        drain(32'h44332211, 8'b1011_0100, 8);

        // short read12
        arm();
        read12 = 1; cyc(); read12 = 0; cyc();
        chk("short.serr", seq_err, 1);
        no_out("short.nov", 4);
        arm();
        reads(32'hD4C3B2A1);
        drain(32'hD4C3B2A1, 8'hFF, 4);
        chk("short.sticky", seq_err, 1);

        // read34 in CONV
        do_reset("rst2");
        arm();
        read34 = 1; cyc(); read34 = 0; cyc();
        chk("ord1.serr", seq_err, 1);
        no_out("ord1.nov", 3);

        // read12 and read34 together
        do_reset("rst3");
        arm();
        read12 = 1; read34 = 1; cyc(); read12 = 0; read34 = 0; cyc();
        chk("ord2.serr", seq_err, 1);
        no_out("ord2.nov", 3);

        // erase during a stalled drain
        do_reset("rst4");
        arm();
        reads(32'hA4A3A2A1);
        pix_ready = 0; erase = 1; cyc(); erase = 0;
        chk("ovr.flag", overrun, 1);
        chk("ovr.data", pix_data, 8'hA1);
        chk("ovr.idx", pix_idx, 0);
        drain(32'hA4A3A2A1, 8'hFF, 4);
        chk("ovr.sticky", overrun, 1);
        chk("ovr.serr", seq_err, 0);
        // the lost frame: no erase, so strobes alone produce nothing
        convert = 1; cyc(); convert = 0;
        read12 = 1; cyc(); cyc(); read12 = 0;
        read34 = 1; cyc(); cyc(); read34 = 0;
        no_out("ovr.nov", 3);

        // erase in WAIT34 restarts the frame
        erase = 1; cyc(); erase = 0;
        convert = 1; cyc(); convert = 0;
        read12 = 1; pixData1 = 8'hB1; pixData2 = 8'hB2;
        cyc(); cyc(); cyc();
        read12 = 0; pixData1 = 0; pixData2 = 0;
        erase = 1; cyc(); erase = 0;
        chk("restart.nov", pix_valid, 0);
        convert = 1; cyc(); convert = 0;
        reads(32'hC4C3C2C1);
        drain(32'hC4C3C2C1, 8'hFF, 4);
        chk("restart.serr", seq_err, 0);

        // 256 frames wrap the counter
        do_reset("rst5");
        for (int i = 0; i < 256; i++) begin
            logic [31:0] d;
            d = {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)};
            arm();
            reads(d);
            drain(d, 8'hFF, 4);
        end
        chk("wrap", frame_count, 0);

        // reset in the middle of a drain
        arm();
        reads(32'h87654321);
        pix_ready = 1; cyc(); pix_ready = 0;
        chk("mid.idx", pix_idx, 1);
        #3;
        do_reset("mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
